ncm_nlfsr_ctrl: RTL and testbench



---
 rtl/ncm_nlfsr_ctrl_if.sv | 29 ++
 rtl/ncm_nlfsr_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ncm_nlfsr_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ncm_nlfsr_ctrl_if.sv
// Command and keystream-output handshake bundle for the NLFSR sequencer.
// The master side issues jobs and consumes words; the slave side is the sequencer.
interface ncm_nlfsr_ctrl_if #(
    parameter int SEED_W = 56,
    parameter int CNT_W  = 16,
    parameter int WORD_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [SEED_W-1:0] cmd_seed;
    logic [CNT_W-1:0]  cmd_warmup;
    logic [CNT_W-1:0]  cmd_nwords;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_seed, cmd_warmup, cmd_nwords, abort, out_ready,
        input  cmd_ready, out_valid, out_data, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_seed, cmd_warmup, cmd_nwords, abort, out_ready,
        output cmd_ready, out_valid, out_data, busy, done
    );
endinterface

// File: rtl/ncm_nlfsr_ctrl.sv
// Job sequencer for the dual NLFSR: loads a seed, runs warm-up steps, then packs
// the keystream bit into words and streams them out, halting the NLFSR on backpressure.
module ncm_nlfsr_ctrl #(
    parameter int SEED_W = 56,
    parameter int CNT_W  = 16,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ncm_nlfsr_ctrl_if.slave   bus,
    output logic [SEED_W-1:0] nl_wdata,
    output logic              nl_load,
    output logic              nl_halt,
    input  logic [SEED_W-1:0] nl_rdata
);
    localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WARMUP,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  warm_q, warm_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
    logic [WORD_W-2:0] coll_q, coll_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              done_q, done_d;
    logic              nl_load_q, nl_load_d;
    logic [SEED_W-1:0] nl_wdata_q, nl_wdata_d;

    logic ks;
    logic word_last;
    logic stall;
    logic accept;
    logic rdata_unused;

    // Keystream bit: low bit of the 29-bit register XOR low bit of the 27-bit register.
    assign ks           = nl_rdata[27] ^ nl_rdata[0];
    assign rdata_unused = ^{nl_rdata[SEED_W-1:28], nl_rdata[26:1]};

    assign word_last = (bitcnt_q == BIT_LAST);
    // Freeze the generator only when the next step would overwrite an unaccepted word.
    assign stall     = word_last && out_valid_q && !bus.out_ready;
    assign accept    = out_valid_q && bus.out_ready;

    always_comb begin
        nl_halt = 1'b1;
        case (state_q)
            S_WARMUP: nl_halt = 1'b0;
            S_RUN:    nl_halt = stall;
            default:  nl_halt = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        words_d     = words_q;
        bitcnt_d    = bitcnt_q;
        coll_d      = coll_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        nl_load_d   = 1'b0;
        nl_wdata_d  = nl_wdata_q;

        if (accept) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    nl_wdata_d = bus.cmd_seed;
                    warm_d     = bus.cmd_warmup;
                    words_d    = bus.cmd_nwords;
                    nl_load_d  = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (warm_q != '0) begin
                    state_d = S_WARMUP;
                end else if (words_q != '0) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_WARMUP: begin
                warm_d = warm_q - CNT_W'(1);
                if (warm_q == CNT_W'(1)) begin
                    state_d = (words_q != '0) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (word_last) begin
                        out_data_d  = {coll_q, ks};
                        out_valid_d = 1'b1;
                        bitcnt_d    = '0;
                        words_d     = words_q - CNT_W'(1);
                        if (words_q == CNT_W'(1)) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        coll_d   = {coll_q[WORD_W-3:0], ks};
                        bitcnt_d = bitcnt_q + BC_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!out_valid_q || bus.out_ready) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Cancellation leaves out_data and the NLFSR contents untouched.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            bitcnt_d    = '0;
            warm_d      = '0;
            words_d     = '0;
            coll_d      = '0;
            done_d      = 1'b0;
            nl_load_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            warm_q      <= '0;
            words_q     <= '0;
            bitcnt_q    <= '0;
            coll_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            nl_load_q   <= 1'b0;
            nl_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            words_q     <= words_d;
            bitcnt_q    <= bitcnt_d;
            coll_q      <= coll_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            nl_load_q   <= nl_load_d;
            nl_wdata_q  <= nl_wdata_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;
    assign nl_load       = nl_load_q;
    assign nl_wdata      = nl_wdata_q;
endmodule

// File: tb/tb_ncm_nlfsr_ctrl.sv
// Directed bench for ncm_nlfsr_ctrl with a stand-in NLFSR, a per-cycle job-level
// model of the sequencer, and literal expectations for timing and data.
module tb_ncm_nlfsr_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    ncm_nlfsr_ctrl_if #(.SEED_W(56), .CNT_W(16), .WORD_W(16)) bus ();

    logic [55:0] nl_wdata;
    logic        nl_load;
    logic        nl_halt;
    logic [55:0] nl_rdata;
    logic [55:0] nl_state = '0;
    logic        use_stub = 1'b0;
    logic [55:0] stub_val = '0;

    ncm_nlfsr_ctrl #(.SEED_W(56), .CNT_W(16), .WORD_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .nl_wdata (nl_wdata),
        .nl_load  (nl_load),
        .nl_halt  (nl_halt),
        .nl_rdata (nl_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in dual NLFSR: {29-bit reg, 27-bit reg} with small nonlinear feedbacks.
    function automatic logic [55:0] nl_step(input logic [55:0] s);
        logic [28:0] a;
        logic [26:0] b;
        logic        fa, fb;
        a  = s[55:27];
        b  = s[26:0];
        fa = a[0] ^ a[2] ^ (a[5] & a[11]) ^ b[3];
        fb = b[0] ^ b[1] ^ (b[4] & b[9]) ^ a[7];
        return {fa, a[28:1], fb, b[26:1]};
    endfunction

    function automatic logic ks_of(input logic [55:0] s);
        return s[27] ^ s[0];
    endfunction

    always @(posedge clk) begin
        if (nl_load) nl_state <= nl_wdata;
        else if (!nl_halt) nl_state <= nl_step(nl_state);
    end
    assign nl_rdata = use_stub ? stub_val : nl_state;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- job-level model, checked every cycle ----------------
    bit          mon_en = 1'b0;
    bit          m_active = 1'b0;
    int          m_jc, m_w, m_n, m_steps, m_acc;
    logic [15:0] m_words[$];

    always @(negedge clk) begin
        int          rs, compl;
        logic        exp_ov, exp_halt;
        logic [55:0] st;
        logic [15:0] wd;
        if (mon_en) begin
            if (m_active) m_jc++;
            if (bus.done) begin
                chk("done_legit", m_active, 1);
                if (m_active) begin
                    chk("done_words", m_acc, m_n);
                    chk("done_steps", m_steps, m_w + 16 * m_n);
                    m_active = 1'b0;
                end
            end
            rs     = (m_steps > m_w) ? m_steps - m_w : 0;
            compl  = rs / 16;
            if (compl > m_n) compl = m_n;
            exp_ov = m_active && (compl != m_acc);
            if (!m_active || m_jc == 1) exp_halt = 1'b1;
            else if (m_steps < m_w) exp_halt = 1'b0;
            else if (rs < 16 * m_n) exp_halt = (rs % 16 == 15) && exp_ov && !bus.out_ready;
            else exp_halt = 1'b1;
            chk("out_valid", bus.out_valid, exp_ov);
            chk("nl_halt", nl_halt, exp_halt);
            chk("busy", bus.busy, m_active);
            chk("cmd_ready", bus.cmd_ready, !m_active);
            chk("nl_load", nl_load, m_active && (m_jc == 1));
            if (bus.out_valid && bus.out_ready && m_active) begin
                chk("word_in_range", (m_acc < m_n), 1);
                if (m_acc < m_n) chk("word_data", bus.out_data, m_words[m_acc]);
                m_acc++;
            end
            if (!nl_halt && m_active) m_steps++;
            if (bus.abort && m_active) m_active = 1'b0;
            else if (bus.cmd_valid && !m_active) begin
                m_active = 1'b1;
                m_jc = 0; m_steps = 0; m_acc = 0;
                m_w = int'(bus.cmd_warmup);
                m_n = int'(bus.cmd_nwords);
                m_words.delete();
                st = bus.cmd_seed;
                for (int i = 0; i < m_w; i++) st = nl_step(st);
                for (int k = 0; k < m_n; k++) begin
                    wd = '0;
                    for (int b = 0; b < 16; b++) begin
                        wd = {wd[14:0], use_stub ? ks_of(stub_val) : ks_of(st)};
                        if (!use_stub) st = nl_step(st);
                    end
                    m_words.push_back(wd);
                end
            end
        end
    end

    // ---------------- directed job driver ----------------
    int          r_T, r_first_ov, r_done_at, r_ndone, r_halt0, r_warm0;
    logic        r_ov_at_abort;
    int          r_wcyc[$];
    logic [15:0] r_wdat[$];

    task automatic run_job(input logic stub, input logic [55:0] sv, input logic [55:0] seed,
                           input int w, input int n, input int hold, input int abort_rel);
        int rel_done;
        bit fin;
        use_stub = stub;
        stub_val = sv;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_seed   = seed;
        bus.cmd_warmup = 16'(w);
        bus.cmd_nwords = 16'(n);
        bus.abort      = 1'b0;
        bus.out_ready  = (hold == 0);
        @(negedge clk);
        chk("accept_ready", bus.cmd_ready, 1);
        r_T = cyc; r_first_ov = -1; r_done_at = -1; r_ndone = 0; r_halt0 = 0; r_warm0 = 0;
        r_ov_at_abort = 1'b0;
        r_wcyc.delete(); r_wdat.delete();
        rel_done = -1; fin = 1'b0;
        for (int rel = 1; rel <= 3000 && !fin; rel++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            bus.abort     = (rel == abort_rel);
            bus.out_ready = (hold == 0) || (r_first_ov >= 0 && cyc - r_first_ov >= hold);
            @(negedge clk);
            if (rel == 1) begin
                chk("load_pulse", nl_load, 1);
                chk("load_wdata", nl_wdata, seed);
            end
            if (rel == 2) chk("load_once", nl_load, 0);
            if (!nl_halt) begin
                r_halt0++;
                if (rel >= 2 && rel <= 1 + w) r_warm0++;
            end
            if (bus.out_valid && r_first_ov < 0) r_first_ov = cyc;
            if (bus.out_valid && bus.out_ready) begin
                r_wcyc.push_back(cyc);
                r_wdat.push_back(bus.out_data);
            end
            if (rel == abort_rel) r_ov_at_abort = bus.out_valid;
            if (bus.done) begin
                r_ndone++;
                if (r_done_at < 0) begin r_done_at = cyc; rel_done = rel; end
            end
            if (abort_rel > 0 && rel == abort_rel + 1) begin
                chk("abort_idle", bus.busy, 0);
                chk("abort_ov", bus.out_valid, 0);
                chk("abort_nodone", bus.done, 0);
                fin = 1'b1;
            end
            if (rel_done > 0 && rel == rel_done + 1) fin = 1'b1;
        end
        chk("job_finished", fin, 1);
        bus.abort = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_seed = '0; bus.cmd_warmup = '0; bus.cmd_nwords = '0;
        bus.abort = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_nl_halt", nl_halt, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_nl_load", nl_load, 0);
        chk("rst_nl_wdata", nl_wdata, 0);
        mon_en = 1'b1;

        // Real NLFSR, seed from the reset/idle scenario.
        run_job(1'b0, 56'h0, 56'h00C0FFEE123456, 2, 2, 0, 0);
        chk("t1_words", r_wcyc.size(), 2);
        chk("t1_first_ov", r_first_ov, r_T + 20);
        chk("t1_ndone", r_ndone, 1);

        // Stubbed ks=1.
        run_job(1'b1, 56'h00000000000001, 56'h00000000000001, 3, 2, 0, 0);
        chk("t2_warm_steps", r_warm0, 3);
        chk("t2_total_steps", r_halt0, 35);
        chk("t2_nwords", r_wcyc.size(), 2);
        if (r_wcyc.size() == 2) begin
            chk("t2_w0_cyc", r_wcyc[0], r_T + 21);
            chk("t2_w0_dat", r_wdat[0], 16'hFFFF);
            chk("t2_w1_cyc", r_wcyc[1], r_T + 37);
            chk("t2_w1_dat", r_wdat[1], 16'hFFFF);
        end
        chk("t2_ndone", r_ndone, 1);
        chk("t2_done_at", r_done_at, r_T + 38);

        // Stubbed ks cancels to 0.
        run_job(1'b1, 56'h00000008000001, 56'h0, 0, 1, 0, 0);
        chk("t3_nwords", r_wcyc.size(), 1);
        if (r_wcyc.size() == 1) begin
            chk("t3_w0_cyc", r_wcyc[0], r_T + 18);
            chk("t3_w0_dat", r_wdat[0], 16'h0000);
        end
        chk("t3_done_at", r_done_at, r_T + 19);

        // Backpressure on a real NLFSR.
        run_job(1'b0, 56'h0, 56'h00000000000001, 5, 3, 20, 0);
        chk("t4_first_ov", r_first_ov, r_T + 23);
        chk("t4_nwords", r_wcyc.size(), 3);
        if (r_wcyc.size() == 3) begin
            chk("t4_w0_cyc", r_wcyc[0], r_T + 43);
            chk("t4_w1_cyc", r_wcyc[1], r_T + 44);
            chk("t4_w2_cyc", r_wcyc[2], r_T + 60);
        end
        chk("t4_steps", r_halt0, 53);
        chk("t4_ndone", r_ndone, 1);

        // Zero warm-up and zero words.
        run_job(1'b0, 56'h0, 56'h00000000001234, 0, 0, 0, 0);
        chk("t5_done_at", r_done_at, r_T + 3);
        chk("t5_steps", r_halt0, 0);
        chk("t5_no_ov", r_first_ov, -1);
        chk("t5_ndone", r_ndone, 1);

        // Abort mid-warm-up.
        run_job(1'b0, 56'h0, 56'h00000000000077, 10, 2, 0, 5);
        chk("t6_ndone", r_ndone, 0);
        chk("t6_nwords", r_wcyc.size(), 0);

        // Abort mid-run with a word pending.
        run_job(1'b0, 56'h0, 56'h00000000000001, 0, 3, 1000000, 25);
        chk("t7_pending", r_ov_at_abort, 1);
        chk("t7_ndone", r_ndone, 0);
        chk("t7_nwords", r_wcyc.size(), 0);

        // Next command after aborts runs cleanly.
        run_job(1'b0, 56'h0, 56'hA5A50F0F3C3C99, 1, 4, 0, 0);
        chk("t8_nwords", r_wcyc.size(), 4);
        chk("t8_first_ov", r_first_ov, r_T + 19);
        chk("t8_ndone", r_ndone, 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
